// File: rtl/oob_mem_pkg.sv
// Shared types and widths for the out-of-band program-load memory target.
package oob_mem_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } state_t;

endpackage

// File: rtl/oob_mem_if.sv
// Bus bundle between the load driver / comp core (master) and the memory target (slave).
// Carries the OOB load strobe path and the CPU request/ack memory port.
interface oob_mem_if;
    import oob_mem_pkg::*;

    logic [ADDR_W-1:0] oob_write_addr;
    logic [WORD_W-1:0] oob_write_data;
    logic              oob_mem_wen;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output oob_write_addr, oob_write_data, oob_mem_wen,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  oob_write_addr, oob_write_data, oob_mem_wen,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/sp_ram_1r1w.sv
// DEPTH x WIDTH storage array: one write port, one registered read port.
// The array and the read register carry no reset; the owner masks stale read data.
module sp_ram_1r1w #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port: output updates only on an enabled read, otherwise holds.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/oob_mem_target.sv
// Receiving end of the out-of-band program-load interface. Owns the unified
// program/data memory, holds the comp core in reset while a load is in progress
// and for a settle window afterwards, and arbitrates OOB writes against the CPU port.
module oob_mem_target
    import oob_mem_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    oob_mem_if.slave          bus,
    output logic              cpu_rst,
    output logic [WORD_W-1:0] load_count,
    output logic              load_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  settle_cnt;
    logic              settle_done;

    logic              oob_in_range;
    logic              cpu_in_range;
    logic              cpu_accept;

    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_re;
    logic [WORD_W-1:0] ram_rdata;
    logic              rd_blank;

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (v == '1) ? v : v + WORD_W'(1);
    endfunction

    assign oob_in_range = ({1'b0, bus.oob_write_addr} < DEPTH_L);
    assign cpu_in_range = ({1'b0, bus.mem_addr} < DEPTH_L);
    assign settle_done  = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));

    // The CPU gets the port only in RUN, never against an OOB strobe, and never
    // in the cycle its previous ack is showing, so back-to-back accepts are impossible.
    assign cpu_accept = (state == RUN) && !bus.oob_mem_wen && bus.mem_req && !bus.mem_ack;

    // Write-port mux: OOB has priority; out-of-range addresses never reach the array.
    assign ram_we    = (bus.oob_mem_wen && oob_in_range) ||
                       (cpu_accept && bus.mem_we && cpu_in_range);
    assign ram_waddr = bus.oob_mem_wen ? bus.oob_write_addr[IDX_W-1:0] : bus.mem_addr[IDX_W-1:0];
    assign ram_wdata = bus.oob_mem_wen ? bus.oob_write_data : bus.mem_wdata;
    assign ram_re    = cpu_accept && !bus.mem_we && cpu_in_range;

    // Out-of-range reads (and the post-reset state) present zero instead of stale array data.
    assign bus.mem_rdata = rd_blank ? '0 : ram_rdata;
    assign load_done     = (state == RUN);

    sp_ram_1r1w #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (bus.mem_addr[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: any OOB strobe (re)enters LOAD; a quiet settle window leads to RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.oob_mem_wen) next_state = LOAD;
            LOAD:    if (!bus.oob_mem_wen) next_state = SETTLE;
            SETTLE: begin
                if (bus.oob_mem_wen) begin
                    next_state = LOAD;
                end else if (settle_done) begin
                    next_state = RUN;
                end
            end
            RUN:     if (bus.oob_mem_wen) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Settle counter: cleared while loading, advances on each quiet SETTLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == LOAD) begin
            settle_cnt <= '0;
        end else if (state == SETTLE && next_state == SETTLE) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    // Core reset follows the upcoming state so it drops on the edge RUN is entered
    // and rises on the edge a reload strobe is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst <= 1'b1;
        end else begin
            cpu_rst <= (next_state != RUN);
        end
    end

    // Load word counter: a fresh load from IDLE or RUN restarts at one, otherwise saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count <= '0;
        end else if (bus.oob_mem_wen) begin
            if (state == IDLE || state == RUN) begin
                load_count <= WORD_W'(1);
            end else begin
                load_count <= sat_inc(load_count);
            end
        end
    end

    // Ack pulse and read-data masking flag, both one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ack <= 1'b0;
            rd_blank    <= 1'b1;
        end else begin
            bus.mem_ack <= cpu_accept;
            if (cpu_accept && !bus.mem_we) begin
                rd_blank <= !cpu_in_range;
            end
        end
    end

endmodule
